// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
// Holds the load-FSM state enum, the instruction width and the default NOP.
package imem_pkg;

    localparam int INSTR_W = 32;

    // RISC-V addi x0,x0,0, returned on a faulting fetch.
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    // One registered fetch response.
    typedef struct packed {
        logic               fault;
        logic [INSTR_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Load-mode controller: RUN/LOAD FSM, write pointer, word count, busy.
// Ports: clk, reset (sync, active-high); ld_start/ld_valid/ld_last in;
//   rsp_idle in (no fetch response is left pending this cycle);
//   ld_ready, busy, ld_count, run out; wr_en/wr_addr drive the array.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic                     ld_last,
    input  logic                     rsp_idle,
    output logic                     ld_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic                     run,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_e        r_state;
    logic [AW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic          r_ld_ready;
    logic          r_busy;

    logic w_beat;
    logic w_end;

    // ld_ready is a registered copy of the LOAD state, so a beat is
    // simply ld_valid while ld_ready is up.
    assign w_beat = r_ld_ready && ld_valid;

    // Leave on the last-marked beat or when the array fills.
    assign w_end = w_beat
                && (ld_last || (r_wptr == AW'(DEPTH - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_wptr     <= '0;
            r_count    <= '0;
            r_ld_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (ld_start && rsp_idle) begin
                        r_state    <= LOAD;
                        r_wptr     <= '0;
                        r_count    <= '0;
                        r_ld_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_beat) begin
                        r_wptr  <= r_wptr + AW'(1);
                        r_count <= r_count + CW'(1);
                    end
                    if (w_end) begin
                        r_state    <= RUN;
                        r_ld_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ld_ready = r_ld_ready;
    assign busy     = r_busy;
    assign ld_count = r_count;
    assign run      = (r_state == RUN);

    // A reset cycle must not scribble on the array.
    assign wr_en   = w_beat && !reset;
    assign wr_addr = r_wptr;

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with valid/ready fetch and load port.
// Ports: clk, reset; req_valid/req_ready/req_addr fetch request;
//   rsp_valid/rsp_ready/rsp_data/rsp_fault response (1-cycle latency);
//   ld_start/ld_valid/ld_ready/ld_data/ld_last load stream; ld_count, busy.
// Macro IMEM_BOUNDS_CHECK_EN enables misaligned/out-of-range fault reporting.
module imem_sync
    import imem_pkg::*;
#(
    parameter int unsigned        DEPTH     = 64,
    parameter logic [INSTR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_WORD  = imem_pkg::NOP_WORD
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [INSTR_W-1:0]     req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [INSTR_W-1:0]     rsp_data,
    output logic                   rsp_fault,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [INSTR_W-1:0]     ld_data,
    input  logic                   ld_last,
    output logic [$clog2(DEPTH):0] ld_count,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic               r_rsp_valid;
    rsp_t               r_rsp;

    logic               w_run;
    logic               w_rsp_idle;
    logic               w_req_acc;
    logic [INSTR_W-1:0] w_off;
    logic [AW-1:0]      w_idx;
    logic               w_fault;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;
    logic               w_unused;

    imem_load_ctrl #(
        .DEPTH (DEPTH)
    ) u_load_ctrl (
        .clk      (clk),
        .reset    (reset),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_last  (ld_last),
        .rsp_idle (w_rsp_idle),
        .ld_ready (ld_ready),
        .busy     (busy),
        .ld_count (ld_count),
        .run      (w_run),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr)
    );

    // The output slot is free when empty or drained this cycle.
    assign w_rsp_idle = !r_rsp_valid || rsp_ready;
    assign req_ready  = w_run && w_rsp_idle;
    assign w_req_acc  = req_valid && req_ready;

    assign w_off = req_addr - BASE_ADDR;
    assign w_idx = w_off[2 +: AW];

`ifdef IMEM_BOUNDS_CHECK_EN
    // Any offset bit at or above DEPTH*4 means out of range.
    assign w_fault = (req_addr[1:0] != 2'b00)
                  || (req_addr < BASE_ADDR)
                  || (|w_off[INSTR_W-1:AW+2]);
    assign w_unused = ^w_off[1:0];
`else
    // Byte-lane bits ignored, index wraps modulo DEPTH.
    assign w_fault  = 1'b0;
    assign w_unused = ^{w_off[INSTR_W-1:AW+2], w_off[1:0]};
`endif

    // Array: no reset, written only in LOAD (fetch is blocked there).
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= ld_data;
        end
    end

    // Response register: loads on accept, holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp.data  <= NOP_WORD;
            r_rsp.fault <= 1'b0;
        end else if (w_req_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp.data  <= w_fault ? NOP_WORD : r_mem[w_idx];
            r_rsp.fault <= w_fault;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp.data;
    assign rsp_fault = r_rsp.fault;

endmodule

// File: tb/tb_imem_sync.sv
// Self-checking bench for imem_sync: table vectors plus scoreboard queue.
// Responses are popped and compared at the falling edge when consumed.
module tb_imem_sync;

    localparam int DEPTH = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0050_0093;
    localparam logic [31:0] W1  = 32'h00A0_0113;
    localparam logic [31:0] W2  = 32'h0020_81B3;
    localparam logic [31:0] N0  = 32'h0010_0093;
    localparam logic [31:0] N1  = 32'h0020_0113;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [6:0]  ld_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [32:0] sb[$];
    logic [31:0] ld_buf[DEPTH+2];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    vec_t vecs[6];

    imem_sync #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0000_0000),
        .NOP_WORD  (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_fault (rsp_fault),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_count  (ld_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("rsp_data", rsp_data, e[31:0]);
                chk("rsp_fault", 32'(rsp_fault), 32'(e[32]));
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        ld_start  = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    // Issue one fetch; expectation queued when the accept is seen.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                         input logic f);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("fetch_accept_timeout", 32'(ok), 32'd1);
        if (ok) sb.push_back({f, d});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Stream n words from ld_buf; acc returns the beats accepted.
    task automatic load(input int n, input int last_idx, output int acc);
        bit stopped;
        stopped  = 1'b0;
        acc      = 0;
        ld_start = 1'b1;
        @(posedge clk); #1;
        ld_start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        chk("ld_count_clr", 32'(ld_count), 32'd0);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = ld_buf[i];
            ld_last  = (i == last_idx);
            @(negedge clk);
            if (!ld_ready) begin
                stopped = 1'b1;
                break;
            end
            acc++;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (stopped) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        vecs[0] = '{32'h0, W0, 1'b0};
        vecs[1] = '{32'h4, W1, 1'b0};
        vecs[2] = '{32'h8, W2, 1'b0};
`ifdef IMEM_BOUNDS_CHECK_EN
        vecs[3] = '{32'h2, NOP, 1'b1};
        vecs[4] = '{32'h6, NOP, 1'b1};
        vecs[5] = '{32'(DEPTH * 4), NOP, 1'b1};
`else
        vecs[3] = '{32'h2, W0, 1'b0};
        vecs[4] = '{32'h6, W1, 1'b0};
        vecs[5] = '{32'(DEPTH * 4), W0, 1'b0};
`endif

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, NOP);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        ld_buf[0] = W0;
        ld_buf[1] = W1;
        ld_buf[2] = W2;
        load(3, 2, acc);
        chk("ld3_acc", 32'(acc), 32'd3);
        chk("ld3_count", 32'(ld_count), 32'd3);
        chk("ld3_busy_fall", 32'(busy), 32'd0);
        chk("ld3_ready_fall", 32'(ld_ready), 32'd0);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].addr, vecs[i].data, vecs[i].fault);
            @(negedge clk);
            chk($sformatf("vec%0d_latency", i), 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        drain();

        // Back-to-back fetches, no bubbles.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        @(negedge clk);
        chk("b2b_rdy0", 32'(req_ready), 32'd1);
        sb.push_back({1'b0, W0});
        @(posedge clk); #1;
        req_addr = 32'h4;
        @(negedge clk);
        chk("b2b_v0", 32'(rsp_valid), 32'd1);
        chk("b2b_rdy1", 32'(req_ready), 32'd1);
        sb.push_back({1'b0, W1});
        @(posedge clk); #1;
        req_addr = 32'h8;
        @(negedge clk);
        chk("b2b_v1", 32'(rsp_valid), 32'd1);
        chk("b2b_rdy2", 32'(req_ready), 32'd1);
        sb.push_back({1'b0, W2});
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_v2", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_idle", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        // Stall: response held, requests blocked.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        @(negedge clk);
        chk("hold_acc", 32'(req_ready), 32'd1);
        sb.push_back({1'b0, W1});
        @(posedge clk); #1;
        req_addr = 32'h8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold_valid%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold_data%0d", k), rsp_data, W1);
            chk($sformatf("hold_rdy%0d", k), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", 32'(req_ready), 32'd1);
        sb.push_back({1'b0, W2});
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();

        // Overlong stream with no ld_last.
        for (int i = 0; i < DEPTH + 2; i++) begin
            ld_buf[i] = 32'hA000_0000 + 32'(i);
        end
        load(DEPTH + 2, -1, acc);
        chk("full_acc", 32'(acc), 32'(DEPTH));
        chk("full_count", 32'(ld_count), 32'(DEPTH));
        chk("full_ready_drop", 32'(ld_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        fetch(32'h0, 32'hA000_0000, 1'b0);
        fetch(32'((DEPTH - 1) * 4), 32'hA000_0000 + 32'(DEPTH - 1), 1'b0);
        drain();

        // Reset drops a pending response.
        rsp_ready = 1'b0;
        fetch(32'h4, 32'hA000_0001, 1'b0);
        chk("pend_valid", 32'(rsp_valid), 32'd1);
        do_reset();
        rsp_ready = 1'b1;
        chk("pend_rst_valid", 32'(rsp_valid), 32'd0);
        chk("pend_rst_data", rsp_data, NOP);

        // Reset in the middle of a load.
        ld_buf[0] = N0;
        ld_buf[1] = N1;
        load(2, -1, acc);
        chk("mid_acc", 32'(acc), 32'd2);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_count", 32'(ld_count), 32'd2);
        do_reset();
        chk("mid_rst_count", 32'(ld_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        fetch(32'h0, N0, 1'b0);
        fetch(32'h4, N1, 1'b0);
        fetch(32'h8, 32'hA000_0002, 1'b0);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
